// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I size codes,
// FSM states and fault cause encodings.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_e;

    // Encoding matches the fault_cause_o port directly.
    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        RANGE    = 2'b10,
        ILLEGAL  = 2'b11
    } fault_cause_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends a byte or half from a memory
// word for loads, and merges a byte or half into a memory word for stores.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] rd_word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_data = rd_word;
        endcase
    end

    // Only byte and half stores reach the merge path; other codes pass the word.
    always_comb begin
        st_word = rd_word;
        if (funct3[1:0] == 2'b00) begin
            st_word[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3[1:0] == 2'b01) begin
            st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: checks requests, extends loads into a
// registered result and runs sub-word stores as a two-cycle read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DM_DEPTH = 4096
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            dm_we_o,
    output logic [XLEN-1:0] dm_a_o,
    output logic [XLEN-1:0] dm_wd_o,
    input  logic [XLEN-1:0] dm_rd_i,
    output logic            ld_valid_o,
    output logic [XLEN-1:0] ld_data_o,
    output logic            fault_o,
    output logic [1:0]      fault_cause_o,
    output logic [XLEN-1:0] fault_addr_o,
    output lsu_state_e      dbg_state_o
);

    // Handshake: a request is taken on any rising edge where req_i=1 and
    // stall_o=0; while stall_o=1 upstream holds req_i/we_i/funct3_i/addr_i/wdata_i.

    lsu_state_e      state_q, state_d;
    fault_cause_e    cause, fault_cause_q;
    logic [XLEN-1:0] word_idx;
    logic [XLEN-1:0] wa_q;
    logic [XLEN-1:0] buf_q;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] st_merge;
    logic            is_illegal, is_misalign, is_range;
    logic            do_load, do_fault, do_rmw;

    assign word_idx = {2'b00, addr_i[XLEN-1:2]};

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .funct3  (funct3_i),
        .lane    (addr_i[1:0]),
        .rd_word (dm_rd_i),
        .wdata   (wdata_i),
        .ld_data (ld_ext),
        .st_word (st_merge)
    );

    always_comb begin
        is_illegal  = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                      (we_i && funct3_i[2]);
        is_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        is_range    = word_idx >= XLEN'(DM_DEPTH);
        if (is_illegal)       cause = ILLEGAL;
        else if (is_misalign) cause = MISALIGN;
        else if (is_range)    cause = RANGE;
        else                  cause = NONE;
    end

    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        dm_we_o  = 1'b0;
        dm_a_o   = word_idx;
        dm_wd_o  = wdata_i;
        do_load  = 1'b0;
        do_fault = 1'b0;
        do_rmw   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (cause != NONE) begin
                        do_fault = 1'b1;
                    end else if (!we_i) begin
                        do_load = 1'b1;
                    end else if (funct3_i == F3_W) begin
                        dm_we_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        do_rmw  = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                dm_a_o  = wa_q;
                dm_we_o = 1'b1;
                dm_wd_o = buf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            ld_valid_o    <= 1'b0;
            ld_data_o     <= '0;
            fault_o       <= 1'b0;
            fault_cause_q <= NONE;
            fault_addr_o  <= '0;
            buf_q         <= '0;
            wa_q          <= '0;
        end else begin
            state_q    <= state_d;
            ld_valid_o <= do_load;
            fault_o    <= do_fault;
            if (do_load) begin
                ld_data_o <= ld_ext;
            end
            if (do_fault) begin
                fault_cause_q <= cause;
                fault_addr_o  <= addr_i;
            end
            if (do_rmw) begin
                buf_q <= st_merge;
                wa_q  <= word_idx;
            end
        end
    end

    assign fault_cause_o = fault_cause_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed checks, randomized traffic against a
// byte-level reference memory, and a scoreboard of load/fault responses.
module tb_load_store_unit;

    localparam int XLEN     = 32;
    localparam int DM_DEPTH = 4096;
    localparam int NWORDS   = 16;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            req_i = 1'b0;
    logic            we_i = 1'b0;
    logic [2:0]      funct3_i = 3'b000;
    logic [31:0]     addr_i = 32'h0;
    logic [31:0]     wdata_i = 32'h0;
    logic            stall_o, dm_we_o, ld_valid_o, fault_o;
    logic [31:0]     dm_a_o, dm_wd_o, dm_rd_i, ld_data_o, fault_addr_o;
    logic [1:0]      fault_cause_o;
    lsu_pkg::lsu_state_e dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // {is_fault, cause, fault_addr, load_data}
    logic [66:0] exp_q[$];
    logic [66:0] mon_e;

    logic [31:0] mem[0:NWORDS-1];
    logic [31:0] ref_mem[0:NWORDS-1];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_a = 4'h0;
    logic [31:0] bd_d = 32'h0;

    logic        c0_stall, c0_we, c1_stall, c1_we;
    logic [31:0] c0_a, c0_wd, c1_a, c1_wd;
    int          c1_cycles;

    load_store_unit #(.XLEN(XLEN), .DM_DEPTH(DM_DEPTH)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .req_i         (req_i),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .dm_we_o       (dm_we_o),
        .dm_a_o        (dm_a_o),
        .dm_wd_o       (dm_wd_o),
        .dm_rd_i       (dm_rd_i),
        .ld_valid_o    (ld_valid_o),
        .ld_data_o     (ld_data_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .fault_addr_o  (fault_addr_o),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    assign dm_rd_i = (dm_a_o < NWORDS) ? mem[dm_a_o[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_a] <= bd_d;
        else if (dm_we_o && dm_a_o < NWORDS) mem[dm_a_o[3:0]] <= dm_wd_o;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: returns cause (0 = legal) and applies stores byte-wise.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [1:0] cause);
        int size;
        int off;
        int widx;
        logic [31:0] word;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        off  = int'(addr % 4);
        widx = int'(addr >> 2);
        if (size == 0 || (we && f3 >= 3'd4))        cause = 2'd3;
        else if ((addr % size) != 0)                cause = 2'd1;
        else if ((addr >> 2) >= DM_DEPTH)           cause = 2'd2;
        else                                        cause = 2'd0;
        if (cause != 2'd0) begin
            exp_q.push_back({1'b1, cause, addr, 32'h0});
        end else if (widx < NWORDS) begin
            word = ref_mem[widx];
            if (!we) begin
                v = word >> (8 * off);
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
                end
                exp_q.push_back({1'b0, 2'b00, 32'h0, v});
            end else begin
                for (int k = 0; k < size; k++) word[8*(off+k) +: 8] = wd[8*k +: 8];
                ref_mem[widx] = word;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_i = 1'b0;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        logic [1:0] cause;
        logic       exp_word_st, exp_sub_st;
        @(negedge clk);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        model(we, f3, addr, wd, cause);
        exp_word_st = (cause == 2'd0) && we && (f3 == 3'd2);
        exp_sub_st  = (cause == 2'd0) && we && (f3 != 3'd2);
        #1;
        c0_stall = stall_o; c0_we = dm_we_o; c0_a = dm_a_o; c0_wd = dm_wd_o;
        c1_stall = 1'b0; c1_we = 1'b0; c1_a = 32'h0; c1_wd = 32'h0;
        c1_cycles = 0;
        while (stall_o && c1_cycles < 4) begin
            @(negedge clk);
            #1;
            c1_cycles++;
            c1_stall = stall_o; c1_we = dm_we_o; c1_a = dm_a_o; c1_wd = dm_wd_o;
        end
        if (stall_o) begin
            n_tests++; n_fail++;
            $display("FAIL stall_timeout: stall_o still 1 after %0d cycles, required 0", c1_cycles);
        end
        check("c0_dm_we", 32'(c0_we), 32'(exp_word_st));
        check("c0_stall", 32'(c0_stall), 32'(exp_sub_st));
        if (exp_sub_st) begin
            check("rmw_cycles", c1_cycles, 1);
            check("rmw_c1_we", 32'(c1_we), 32'd1);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (arst_n && (ld_valid_o || fault_o)) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_output: ld_valid=%0b fault=%0b with no expected response",
                         ld_valid_o, fault_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_is_fault", 32'(fault_o), 32'(mon_e[66]));
                check("resp_ld_valid", 32'(ld_valid_o), 32'(!mon_e[66]));
                if (mon_e[66]) begin
                    check("fault_cause", 32'(fault_cause_o), 32'(mon_e[65:64]));
                    check("fault_addr", fault_addr_o, mon_e[63:32]);
                end else begin
                    check("ld_data", ld_data_o, mon_e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] v;

        // Preload memory through the backdoor while the DUT is held in reset.
        for (int i = 0; i < NWORDS; i++) begin
            v = (i == 8) ? 32'hAAAAAAAA : $urandom;
            ref_mem[i] = v;
            @(negedge clk);
            bd_we = 1'b1; bd_a = 4'(i); bd_d = v;
        end
        @(negedge clk);
        bd_we = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check("rst_ld_valid", 32'(ld_valid_o), 32'd0);
        check("rst_ld_data", ld_data_o, 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_dm_we", 32'(dm_we_o), 32'd0);

        // Word store then loads of every width.
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_dm_a", c0_a, 32'd4);
        check("sw_dm_wd", c0_wd, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        issue(1'b0, 3'b001, 32'h10, 32'h0);
        issue(1'b0, 3'b101, 32'h12, 32'h0);

        // Sub-word read-modify-write.
        issue(1'b1, 3'b000, 32'h11, 32'h00000055);
        check("sb_c0_stall", 32'(c0_stall), 32'd1);
        check("sb_c0_we", 32'(c0_we), 32'd0);
        check("sb_c1_wd", c1_wd, 32'hDEAD55EF);
        check("sb_c1_a", c1_a, 32'd4);
        check("sb_c1_stall", 32'(c1_stall), 32'd0);
        issue(1'b0, 3'b010, 32'h10, 32'h0);

        // Faults.
        issue(1'b0, 3'b010, 32'h12, 32'h0);
        issue(1'b1, 3'b010, 32'h4000, 32'h12345678);
        issue(1'b0, 3'b110, 32'h10, 32'h0);
        issue(1'b1, 3'b100, 32'h10, 32'h0);
        idle(3);

        // Reset during the WRITE cycle of a half store; inputs change under WRITE.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h20; wdata_i = 32'h1234;
        #1;
        check("rst_rmw_c0_stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h44; wdata_i = 32'h0;
        #1;
        check("write_dm_we", 32'(dm_we_o), 32'd1);
        check("write_dm_a_held", dm_a_o, 32'd8);
        check("write_dm_wd_buf", dm_wd_o, 32'hAAAA1234);
        arst_n = 1'b0;
        #1;
        check("abort_stall", 32'(stall_o), 32'd0);
        check("abort_dm_we", 32'(dm_we_o), 32'd0);
        check("abort_ld_data", ld_data_o, 32'd0);
        check("abort_fault_cause", 32'(fault_cause_o), 32'd0);
        check("abort_fault_addr", fault_addr_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        check("abort_mem8", mem[8], 32'hAAAAAAAA);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) a = 32'h4000 + $urandom_range(0, 1023);
            else a = $urandom_range(0, 4 * NWORDS - 1);
            issue(1'($urandom_range(0, 1)), f3, a, $urandom);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        check("exp_q_drained", exp_q.size(), 0);
        for (int i = 0; i < NWORDS; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
